// File: rtl/aes_block_rx.sv
// rtl/aes_block_rx.sv - beat-serial block receiver with single-entry output buffer
// Optional inter-beat timeout compiled in with AES_BLOCK_RX_TIMEOUT_EN.
module aes_block_rx #(
  parameter int DW        = 8,
  parameter int BW        = 128,
  parameter int MSB_FIRST = 0,
  parameter int TIMEOUT   = 1024
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         shakehand,
  input  logic [DW-1:0]                rx,
  output logic [BW-1:0]                data_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic                         busy_o,
  output logic [$clog2(BW/DW)-1:0]     beat_cnt_o,
  output logic                         ovf_o,
  output logic                         tmo_o
);

  localparam int N  = BW / DW;
  localparam int CW = $clog2(N);

  if ((BW % DW) != 0 || N < 2 || TIMEOUT < 1 || TIMEOUT > (1 << 20)) begin : g_bad_cfg
    $error("aes_block_rx: illegal DW/BW/TIMEOUT combination");
  end

  typedef enum logic {IDLE, FILL} state_t;

  state_t          state_q, state_d;
  logic            shk_q;
  logic            edge_det;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   slot;
  int unsigned     slot_base;
  logic [BW-1:0]   asm_q, asm_d;
  logic            last_beat;
  logic            load;
  logic            drop;
  logic            tmo_fire;

  assign edge_det  = shakehand & ~shk_q;
  assign last_beat = edge_det && (cnt_q == CW'(N - 1));
  // A drain in the same cycle frees the buffer for the incoming block.
  assign load      = last_beat && (!valid_o || ready_i);
  assign drop      = last_beat && valid_o && !ready_i;

  always_comb begin
    slot      = (MSB_FIRST != 0) ? (CW'(N - 1) - cnt_q) : cnt_q;
    slot_base = int'(slot) * DW;
    asm_d     = asm_q;
    asm_d[slot_base +: DW] = rx;
  end

`ifdef AES_BLOCK_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_q;

  // An edge in the expiry cycle wins over the timeout.
  assign tmo_fire = (state_q == FILL) && !edge_det && (idle_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_q <= '0;
    end else if (state_q != FILL || edge_det || tmo_fire) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_q + TW'(1);
    end
  end
`else
  assign tmo_fire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (edge_det) state_d = FILL;
      FILL:    if (last_beat || tmo_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o     = (state_q == FILL);
    beat_cnt_o = cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shk_q <= 1'b1;
      cnt_q <= '0;
      asm_q <= '0;
    end else begin
      shk_q <= shakehand;
      if (edge_det) begin
        asm_q <= asm_d;
        cnt_q <= last_beat ? '0 : cnt_q + CW'(1);
      end else if (tmo_fire) begin
        cnt_q <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_o  <= '0;
      valid_o <= 1'b0;
      ovf_o   <= 1'b0;
      tmo_o   <= 1'b0;
    end else begin
      ovf_o <= drop;
      tmo_o <= tmo_fire;
      if (load) begin
        data_o  <= asm_d;
        valid_o <= 1'b1;
      end else if (ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_aes_block_rx.sv
// tb/tb_aes_block_rx.sv - scoreboard bench for aes_block_rx (LSB-first 8/128 and MSB-first 32/128)
// Timeout expectations follow AES_BLOCK_RX_TIMEOUT_EN.
module tb_aes_block_rx;

  logic         clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         shakehand;
  logic [7:0]   rx;
  logic [127:0] data_o;
  logic         valid_o;
  logic         ready_i;
  logic         busy_o;
  logic [3:0]   beat_cnt_o;
  logic         ovf_o;
  logic         tmo_o;

  logic         shk_b;
  logic [31:0]  rx_b;
  logic [127:0] data_b;
  logic         valid_b;
  logic         ready_b;
  logic         busy_b;
  logic [1:0]   cnt_b;
  logic         ovf_b;
  logic         tmo_b;

  aes_block_rx #(.DW(8), .BW(128), .MSB_FIRST(0), .TIMEOUT(8)) dut_a (
    .clk(clk), .rst(rst), .shakehand(shakehand), .rx(rx),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
    .busy_o(busy_o), .beat_cnt_o(beat_cnt_o), .ovf_o(ovf_o), .tmo_o(tmo_o)
  );

  aes_block_rx #(.DW(32), .BW(128), .MSB_FIRST(1), .TIMEOUT(8)) dut_b (
    .clk(clk), .rst(rst), .shakehand(shk_b), .rx(rx_b),
    .data_o(data_b), .valid_o(valid_b), .ready_i(ready_b),
    .busy_o(busy_b), .beat_cnt_o(cnt_b), .ovf_o(ovf_b), .tmo_o(tmo_b)
  );

  int checks = 0;
  int errors = 0;
  int ovf_seen = 0;
  int tmo_seen = 0;
  int hs_seen = 0;
  int ovf0, tmo0, hs0;

  logic [127:0] sb[$];
  logic [127:0] m_blk = '0;
  int           m_cnt = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (valid_o && ready_i) begin
        logic [127:0] exp_blk;
        exp_blk = (sb.size() > 0) ? sb.pop_front() : 'x;
        hs_seen++;
        check("block", data_o, exp_blk);
      end
      if (ovf_o) ovf_seen++;
      if (tmo_o) tmo_seen++;
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One beat on dut_a; the model pushes the block unless the bench expects it dropped.
  task automatic beat(input logic [7:0] d, input bit drop, input logic rdy);
    shakehand = 1'b1;
    rx        = d;
    ready_i   = rdy;
    m_blk[m_cnt*8 +: 8] = d;
    m_cnt++;
    if (m_cnt == 16) begin
      if (!drop) sb.push_back(m_blk);
      m_cnt = 0;
    end
    @(posedge clk); #1;
    shakehand = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic beat_b(input logic [31:0] d);
    shk_b = 1'b1;
    rx_b  = d;
    @(posedge clk); #1;
    shk_b = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic snap();
    ovf0 = ovf_seen;
    tmo0 = tmo_seen;
    hs0  = hs_seen;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; shakehand = 1'b1; rx = '0; ready_i = 1'b1;
    shk_b = 1'b0; rx_b = '0; ready_b = 1'b0;
    @(posedge clk); #1;
    cycles(3);
    check("rst_valid", 128'(valid_o), 128'd0);
    check("rst_data", data_o, 128'd0);
    check("rst_cnt", 128'(beat_cnt_o), 128'd0);
    check("rst_busy", 128'(busy_o), 128'd0);
    check("rst_ovf", 128'(ovf_o), 128'd0);
    check("rst_tmo", 128'(tmo_o), 128'd0);

    // Strobe held high through reset release must not count as a beat.
    rst = 1'b0;
    cycles(3);
    check("hi_rel_cnt", 128'(beat_cnt_o), 128'd0);
    check("hi_rel_busy", 128'(busy_o), 128'd0);
    shakehand = 1'b0;
    cycles(1);

    // Basic assembly
    snap();
    for (int i = 0; i < 16; i++) begin
      beat(8'(i), 1'b0, 1'b1);
      if (i == 6) check("basic_cnt7", 128'(beat_cnt_o), 128'd7);
    end
    cycles(2);
    check("basic_hs", 128'(hs_seen - hs0), 128'd1);
    check("basic_ovf", 128'(ovf_seen - ovf0), 128'd0);
    check("basic_model", sb.size() == 0 ? m_blk : '0, 128'h0F0E0D0C0B0A09080706050403020100);

    // MSB-first 32/128
    beat_b(32'h00112233);
    beat_b(32'h44556677);
    beat_b(32'h8899AABB);
    check("msb_cnt3", 128'(cnt_b), 128'd3);
    beat_b(32'hCCDDEEFF);
    check("msb_valid", 128'(valid_b), 128'd1);
    check("msb_data", data_b, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    ready_b = 1'b1;
    cycles(1);
    check("msb_drain", 128'(valid_b), 128'd0);
    check("msb_ovf", 128'(ovf_b), 128'd0);

    // Back-pressure and overflow
    snap();
    for (int i = 0; i < 16; i++) beat(8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) beat(8'($urandom), 1'b1, 1'b0);
    cycles(1);
    check("bp_ovf", 128'(ovf_seen - ovf0), 128'd1);
    check("bp_valid", 128'(valid_o), 128'd1);
    check("bp_hold", data_o, sb[0]);
    ready_i = 1'b1;
    cycles(1);
    check("bp_drain", 128'(valid_o), 128'd0);
    check("bp_hs", 128'(hs_seen - hs0), 128'd1);

    // Drain and load in the same cycle
    snap();
    for (int i = 0; i < 16; i++) beat(8'($urandom), 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) beat(8'($urandom), 1'b0, 1'b0);
    beat(8'($urandom), 1'b0, 1'b1);
    cycles(1);
    check("sim_ovf", 128'(ovf_seen - ovf0), 128'd0);
    check("sim_hs", 128'(hs_seen - hs0), 128'd2);
    check("sim_valid", 128'(valid_o), 128'd0);

    // Inter-beat timeout
    snap();
    for (int i = 0; i < 5; i++) beat(8'($urandom), 1'b0, 1'b1);
    check("tmo_cnt5", 128'(beat_cnt_o), 128'd5);
    cycles(6);
    check("tmo_edge_cnt", 128'(beat_cnt_o), 128'd5);
    check("tmo_edge_pulse", 128'(tmo_seen - tmo0), 128'd0);
    cycles(1);
`ifdef AES_BLOCK_RX_TIMEOUT_EN
    check("tmo_cnt0", 128'(beat_cnt_o), 128'd0);
    check("tmo_busy", 128'(busy_o), 128'd0);
    cycles(3);
    check("tmo_pulse", 128'(tmo_seen - tmo0), 128'd1);
    m_cnt = 0;
`else
    check("tmo_off_cnt", 128'(beat_cnt_o), 128'd5);
    check("tmo_off_busy", 128'(busy_o), 128'd1);
    cycles(3);
    check("tmo_off_pulse", 128'(tmo_seen - tmo0), 128'd0);
`endif
    for (int i = 0; i < 16; i++) beat(8'($urandom), 1'b0, 1'b1);
    cycles(2);

    // Reset with a buffered block and a partial block in flight
    do beat(8'($urandom), 1'b0, 1'b0); while (m_cnt != 0);
    check("mid_buf_valid", 128'(valid_o), 128'd1);
    for (int i = 0; i < 7; i++) beat(8'($urandom), 1'b0, 1'b0);
    check("mid_cnt7", 128'(beat_cnt_o), 128'd7);
    snap();
    rst = 1'b1;
    cycles(1);
    check("mid_rst_valid", 128'(valid_o), 128'd0);
    check("mid_rst_data", data_o, 128'd0);
    check("mid_rst_cnt", 128'(beat_cnt_o), 128'd0);
    check("mid_rst_busy", 128'(busy_o), 128'd0);
    check("mid_rst_ovf", 128'(ovf_o), 128'd0);
    check("mid_rst_tmo", 128'(tmo_o), 128'd0);
    sb.delete();
    m_cnt = 0;
    rst = 1'b0;
    cycles(1);
    for (int i = 0; i < 16; i++) beat(8'($urandom), 1'b0, 1'b1);
    cycles(2);
    check("post_rst_hs", 128'(hs_seen - hs0), 128'd1);
    check("post_rst_ovf", 128'(ovf_seen - ovf0), 128'd0);

    check("sb_drained", 128'(sb.size()), 128'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
